// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter between the I-cache and D-cache controllers.
// D-cache has fixed priority; a starvation counter forces an I grant after STARVE_LIMIT D wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rw,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rw,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [3:0] starve_cnt;
  logic       grant_i;
  logic       grant_d;

  // Arbitration decision, only meaningful while IDLE.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_valid && !(i_valid && (starve_cnt == LIMIT)))
        grant_d = 1'b1;
      else if (i_valid)
        grant_i = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d)      next_state = BUSY_D;
        else if (grant_i) next_state = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Winner's request is captured once at grant; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_rw    <= 1'b0;
      mem_wdata <= '0;
    end else if (grant_d) begin
      mem_addr  <= d_addr;
      mem_rw    <= d_rw;
      mem_wdata <= d_wdata;
    end else if (grant_i) begin
      mem_addr  <= i_addr;
      mem_rw    <= i_rw;
      mem_wdata <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_d && i_valid) begin
      if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else if (grant_i || grant_d) begin
      starve_cnt <= '0;
    end
  end

  // Ready pulses are qualified with rst so a completion during reset is dropped.
  always_comb begin
    mem_valid = (state != IDLE);
    busy      = (state != IDLE);
    case (state)
      BUSY_I:  grant = 2'b01;
      BUSY_D:  grant = 2'b10;
      default: grant = 2'b00;
    endcase
    i_ready = rst && (state == BUSY_I) && mem_ready;
    d_ready = rst && (state == BUSY_D) && mem_ready;
    i_rdata = i_ready ? mem_rdata : '0;
    d_rdata = d_ready ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard of expected
// memory transactions, and hand-written reset/starvation/spurious-ready sequences.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          rst;
  logic          i_valid, i_rw, i_ready;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata, i_rdata;
  logic          d_valid, d_rw, d_ready;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_valid, mem_rw, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_rw(i_rw), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_rw(d_rw), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [1:0]    grant;
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          iv;
    logic [AW-1:0] ia;
    logic          irw;
    logic [DW-1:0] iwd;
    logic          dv;
    logic [AW-1:0] da;
    logic          drw;
    logic [DW-1:0] dwd;
    int unsigned   lat;
    logic [DW-1:0] rd;
    logic [1:0]    exp_grant;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [DW-1:0] rd);
    exp_t e;
    e.grant = g;
    e.addr  = (g == 2'b01) ? i_addr  : d_addr;
    e.rw    = (g == 2'b01) ? i_rw    : d_rw;
    e.wdata = (g == 2'b01) ? i_wdata : d_wdata;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Waits for the grant, checks it against the scoreboard, completes after lat cycles.
  task automatic do_txn(input int unsigned lat, input logic keep_i, input logic keep_d);
    exp_t e;
    int unsigned n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!mem_valid && n < 4);
    if (!mem_valid) begin
      check("grant_timeout", 64'(0), 64'(1));
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(0), 64'(1));
      return;
    end
    e = sb.pop_front();
    check("arb_latency", 64'(n), 64'(1));
    check("grant", 64'(grant), 64'(e.grant));
    check("busy", 64'(busy), 64'(1));
    check("mem_addr", 64'(mem_addr), 64'(e.addr));
    check("mem_rw", 64'(mem_rw), 64'(e.rw));
    check("mem_wdata", mem_wdata, e.wdata);
    repeat (lat - 1) tick();
    check("mem_addr_hold", 64'(mem_addr), 64'(e.addr));
    mem_ready = 1'b1;
    mem_rdata = e.rdata;
    #1;
    check("i_ready", 64'(i_ready), 64'(e.grant == 2'b01));
    check("d_ready", 64'(d_ready), 64'(e.grant == 2'b10));
    check("i_rdata", i_rdata, (e.grant == 2'b01) ? e.rdata : 64'd0);
    check("d_rdata", d_rdata, (e.grant == 2'b10) ? e.rdata : 64'd0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    i_valid   = keep_i;
    d_valid   = keep_d;
    #1;
    check("done_mem_valid", 64'(mem_valid), 64'(0));
    check("done_grant", 64'(grant), 64'(0));
    check("done_ready", 64'(i_ready | d_ready), 64'(0));
  endtask

  vec_t       vecs[5];
  logic [1:0] seq[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0040, 1'b0, 64'd0, 1'b0, 16'h0000, 1'b0, 64'd0,
                3, 64'h0123_4567_89AB_CDEF, 2'b01};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 64'd0, 1'b1, 16'h8000, 1'b1, 64'hDEAD_BEEF_0000_0001,
                2, 64'h0, 2'b10};
    vecs[2] = '{1'b1, 16'h1234, 1'b0, 64'd0, 1'b1, 16'h00F0, 1'b0, 64'd0,
                1, 64'hCAFE_F00D_1234_5678, 2'b10};
    vecs[3] = '{1'b1, 16'hFFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16'h0000, 1'b0, 64'd0,
                4, 64'h0, 2'b01};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 64'd0, 1'b1, 16'h0000, 1'b0, 64'd0,
                1, 64'hA5A5_5A5A_0F0F_F0F0, 2'b10};
    seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

    // Reset held with both requesting and a stray mem_ready.
    rst = 1'b0;
    i_valid = 1'b1; i_addr = 16'h0111; i_rw = 1'b0; i_wdata = '0;
    d_valid = 1'b1; d_addr = 16'h0ABC; d_rw = 1'b0; d_wdata = '0;
    mem_ready = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    repeat (3) begin
      tick();
      check("rst_mem_valid", 64'(mem_valid), 64'(0));
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ready", 64'(i_ready | d_ready), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    push_exp(2'b10, 64'h0BAD_0BAD_0BAD_0BAD);
    do_txn(2, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      i_valid = vecs[i].iv; i_addr = vecs[i].ia; i_rw = vecs[i].irw; i_wdata = vecs[i].iwd;
      d_valid = vecs[i].dv; d_addr = vecs[i].da; d_rw = vecs[i].drw; d_wdata = vecs[i].dwd;
      push_exp(vecs[i].exp_grant, vecs[i].rd);
      do_txn(vecs[i].lat, 1'b0, 1'b0);
    end

    // Spurious mem_ready while idle.
    mem_ready = 1'b1;
    #1;
    check("spur_ready", 64'(i_ready | d_ready), 64'(0));
    tick();
    check("spur_grant", 64'(grant), 64'(0));
    check("spur_mem_valid", 64'(mem_valid), 64'(0));

    // mem_ready coincident with the grant edge must not complete the transaction.
    i_valid = 1'b1; i_addr = 16'h0200; i_rw = 1'b0;
    #1;
    check("coinc_i_ready", 64'(i_ready), 64'(0));
    tick();
    mem_ready = 1'b0;
    #1;
    check("coinc_grant", 64'(grant), 64'(1));
    check("coinc_mem_valid", 64'(mem_valid), 64'(1));
    mem_ready = 1'b1;
    mem_rdata = 64'h7777_8888_9999_AAAA;
    #1;
    check("coinc_done_ready", 64'(i_ready), 64'(1));
    check("coinc_done_rdata", i_rdata, 64'h7777_8888_9999_AAAA);
    tick();
    mem_ready = 1'b0;
    i_valid = 1'b0;
    #1;
    check("coinc_idle", 64'(grant), 64'(0));

    // Reset in the middle of an I transaction, with mem_ready arriving during reset.
    i_valid = 1'b1; i_addr = 16'h0300;
    tick();
    check("mid_grant", 64'(grant), 64'(1));
    rst = 1'b0;
    mem_ready = 1'b1;
    i_valid = 1'b0;
    #1;
    check("mid_i_ready", 64'(i_ready), 64'(0));
    tick();
    check("mid_mem_valid", 64'(mem_valid), 64'(0));
    check("mid_grant_clr", 64'(grant), 64'(0));
    check("mid_i_ready2", 64'(i_ready), 64'(0));
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    check("mid_after", 64'(grant), 64'(0));

    // Starvation: both always requesting, D reissues a new address each time.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    i_valid = 1'b1; i_addr = 16'h1000; i_rw = 1'b0; i_wdata = '0;
    d_valid = 1'b1; d_addr = 16'h2000; d_rw = 1'b0; d_wdata = '0;
    for (int k = 0; k < 7; k++) begin
      push_exp(seq[k], 64'(k + 100));
      do_txn(1, 1'b1, 1'b1);
      if (seq[k] == 2'b10) d_addr = d_addr + 16'd1;
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    tick();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single main-memory port between the instruction-cache and data-cache controllers. Each cache controller issues block refill/writeback requests; the arbiter grants one at a time, forwards the granted request to memory as registered outputs, and routes the memory's ready/read data back to the granted requester only. D-cache has fixed priority, with a starvation bound that guarantees the fetch stage forward progress.

## Interface
Parameters:
- ADDR_W, 16, request address width
- DATA_W, 64, memory block data width
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced (1..15)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- i_valid  input  1  I-cache request pending
- i_addr  input  ADDR_W  I-cache request address
- i_rw  input  1  I-cache request type (0 read, 1 write)
- i_wdata  input  DATA_W  I-cache write data
- i_ready  output  1  one-cycle completion pulse to I-cache
- i_rdata  output  DATA_W  read data to I-cache, valid when i_ready
- d_valid, d_addr, d_rw, d_wdata  input  1/ADDR_W/1/DATA_W  D-cache request, same meaning
- d_ready  output  1  one-cycle completion pulse to D-cache
- d_rdata  output  DATA_W  read data to D-cache, valid when d_ready
- mem_valid  output  1  request to memory
- mem_addr  output  ADDR_W  address to memory
- mem_rw  output  1  request type to memory
- mem_wdata  output  DATA_W  write data to memory
- mem_ready  input  1  memory completion pulse
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- grant  output  2  current owner: 00 none, 01 I, 10 D
- busy  output  1  transaction in flight

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: sample i_valid/d_valid. Neither -> stay. Only one -> grant it. Both -> grant D unless starve_cnt == STARVE_LIMIT, then grant I. On grant, register addr/rw/wdata of winner into mem_* and go to BUSY_x.
- starve_cnt (4 bits): increments on each D grant made while i_valid=1; clears on any I grant and whenever a grant is made with i_valid=0. Saturates at STARVE_LIMIT.
- BUSY_x: mem_valid=1, mem_* held constant. On mem_ready=1: x_ready=1 and x_rdata=mem_rdata in that cycle (combinational route); next state IDLE. Other requester's ready stays 0.
- Requesters hold valid and request fields stable until their ready pulse and deassert valid the cycle after it (unless issuing a new request). Arbiter ignores requester field changes once granted; a requester dropping valid mid-transaction does not abort it; ready is still pulsed.
- mem_ready in IDLE is ignored; no ready pulse generated.
- i_rdata/d_rdata: drive mem_rdata when owning ready is high, else 0.
- Reset (rst=0 at clock edge): state IDLE, starve_cnt 0, mem_valid 0, mem_addr 0, mem_rw 0, mem_wdata 0, grant 00, busy 0, i_ready/d_ready 0. Reset mid-transaction abandons it; mem_ready during reset ignored.

## Timing
- Request seen in IDLE at cycle N -> mem_valid=1, grant, busy at N+1 (one-cycle arbitration latency).
- mem_ready at cycle M (M >= N+1) -> x_ready at M, mem_valid/busy/grant cleared at M+1.
- Earliest next mem_valid: M+2 (IDLE at M+1 arbitrates). Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- mem_ready coincident with the grant cycle N is ignored (state still IDLE).
- grant, busy, mem_* are registered; i_ready/d_ready/x_rdata are combinational from mem_ready.

## Test plan
- Reset: hold rst=0 3 cycles with i_valid=d_valid=1 -> all outputs 0, grant=00; release -> D granted, mem_valid=1 one cycle after release.
- Single I read: i_valid=1, i_addr=16'h0040, i_rw=0; memory returns 64'h0123_4567_89AB_CDEF after 3 cycles -> mem_addr=16'h0040 at N+1, i_ready pulse 1 cycle with that data, d_ready stays 0.
- D write: d_rw=1, d_addr=16'h8000, d_wdata=64'hDEAD_BEEF_0000_0001 -> mem_rw=1, mem_wdata matches, d_ready on mem_ready, grant returns to 00.
- Contention/starvation: i_valid and d_valid held high, D reissuing each cycle after ready, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D...; starve_cnt clears after I grant.
- Reset mid-transaction: grant I, assert rst=0 before mem_ready, then mem_ready=1 -> no i_ready, state IDLE, mem_valid 0.
- Spurious mem_ready in IDLE with no requests -> i_ready=d_ready=0, grant stays 00.
